control_fsm: RTL and testbench

//  Multicycle control unit sitting directly upstream of the RV32I datapath: consumes the decoded opcode
//  and drives every datapath enable/mux select. Sequences fetch -> decode -> execute for R-type (OP),

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/rv32i_opcodes.sv | 12 +
 rtl/wait_timer.sv | 34 +++
 rtl/control_fsm.sv | 133 +++++++++++++
 tb/tb_control_fsm.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg (package)
//  Description : State encoding and decoded opcode constants for control_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXEC_OP   = 3'd3,
        S_LOAD_WAIT = 3'd4,
        S_LOAD_WB   = 3'd5,
        S_STORE     = 3'd6,
        S_HALT      = 3'd7
    } ctrl_state_t;

    localparam rv32i_opcodes::rv32i_opcode_t OPC_OP     = 7'b0110011;
    localparam rv32i_opcodes::rv32i_opcode_t OPC_LOAD   = 7'b0000011;
    localparam rv32i_opcodes::rv32i_opcode_t OPC_STORE  = 7'b0100011;
    localparam rv32i_opcodes::rv32i_opcode_t OPC_SYSTEM = 7'b1110011;
endpackage

`default_nettype wire

// File: rtl/rv32i_opcodes.sv
// ============================================================================
//  Module      : rv32i_opcodes (package)
//  Description : RV32I major-opcode type shared by decode and control logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_opcodes;
    typedef logic [6:0] rv32i_opcode_t;
endpackage

`default_nettype wire

// File: rtl/wait_timer.sv
// ============================================================================
//  Module      : wait_timer
//  Description : Loadable down-counter; o_done is high while the count is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
//  Module      : control_fsm
//  Description : Multicycle RV32I control unit (fetch/decode/execute for OP,
//                LOAD, STORE, SYSTEM). Optional macro ILLEGAL_TRAP_EN traps
//                unknown opcodes into HALT with a sticky illegal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_WIDTH      = 32,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 flash_busy,
    output logic                 regfile_wren,
    output logic                 ir_wren,
    output logic                 pc_inc,
    output logic                 mem_wren,
    output logic                 regfile_load_from_mem,
    output logic                 ram_raddr_31_20,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instret
);

    localparam int              TW         = $clog2(MEM_RD_LATENCY + 1);
    localparam logic [TW-1:0]   C_LOAD_VAL = TW'(MEM_RD_LATENCY - 1);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_next;
    logic                 w_timer_load;
    logic                 w_timer_done;
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_instret;

    wait_timer #(
        .WIDTH (TW)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_load_val (C_LOAD_VAL),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_load = 1'b0;
        case (r_state)
            S_IDLE:      if (!flash_busy) w_state_next = S_FETCH;
            S_FETCH:     if (w_timer_done) w_state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_OP:     w_state_next = S_EXEC_OP;
                    OPC_LOAD:   w_state_next = S_LOAD_WAIT;
                    OPC_STORE:  w_state_next = S_STORE;
                    OPC_SYSTEM: w_state_next = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                    default:    w_state_next = S_HALT;
`else
                    default:    w_state_next = S_FETCH;
`endif
                endcase
            end
            S_EXEC_OP:   w_state_next = S_FETCH;
            S_LOAD_WAIT: if (w_timer_done) w_state_next = S_LOAD_WB;
            S_LOAD_WB:   w_state_next = S_FETCH;
            S_STORE:     w_state_next = S_FETCH;
            S_HALT:      w_state_next = S_HALT;
            default:     w_state_next = S_IDLE;
        endcase
        // Timer is armed on entry to either wait state so it counts the full latency there.
        w_timer_load = (w_state_next != r_state) &&
                       ((w_state_next == S_FETCH) || (w_state_next == S_LOAD_WAIT));
    end

    assign ir_wren               = (r_state == S_FETCH) && w_timer_done;
    assign pc_inc                = (r_state == S_FETCH) && w_timer_done;
    assign regfile_wren          = (r_state == S_EXEC_OP) || (r_state == S_LOAD_WB);
    assign regfile_load_from_mem = (r_state == S_LOAD_WB);
    assign mem_wren              = (r_state == S_STORE);
    assign ram_raddr_31_20       = (r_state == S_LOAD_WAIT) || (r_state == S_LOAD_WB) ||
                                   (r_state == S_STORE);
    assign halted                = (r_state == S_HALT);

    assign w_retire = (r_state == S_EXEC_OP) || (r_state == S_LOAD_WB) || (r_state == S_STORE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    assign instret = r_instret;

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_opc_unknown;

    assign w_opc_unknown = (opcode != OPC_OP) && (opcode != OPC_LOAD) &&
                           (opcode != OPC_STORE) && (opcode != OPC_SYSTEM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_DECODE) && w_opc_unknown) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// ============================================================================
//  Module      : tb_control_fsm
//  Description : Scoreboard bench for control_fsm; two instances at latency 1 and 2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_fsm;

    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_SYSTEM = 7'b1110011;
    localparam logic [6:0] T_ILL    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  opcode = T_OP;
    logic        flash_busy = 1'b0;

    logic        rf_1, ir_1, pc_1, mw_1, lm_1, ra_1, h_1, il_1;
    logic        rf_2, ir_2, pc_2, mw_2, lm_2, ra_2, h_2, il_2;
    logic [31:0] instret_1, instret_2;
    logic [7:0]  w_outs1, w_outs2;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];

    always #5 clk = ~clk;

    control_fsm #(.CNT_WIDTH(32), .MEM_RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .opcode(opcode), .flash_busy(flash_busy),
        .regfile_wren(rf_1), .ir_wren(ir_1), .pc_inc(pc_1), .mem_wren(mw_1),
        .regfile_load_from_mem(lm_1), .ram_raddr_31_20(ra_1), .halted(h_1),
        .illegal(il_1), .instret(instret_1)
    );

    control_fsm #(.CNT_WIDTH(32), .MEM_RD_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .opcode(opcode), .flash_busy(flash_busy),
        .regfile_wren(rf_2), .ir_wren(ir_2), .pc_inc(pc_2), .mem_wren(mw_2),
        .regfile_load_from_mem(lm_2), .ram_raddr_31_20(ra_2), .halted(h_2),
        .illegal(il_2), .instret(instret_2)
    );

    // {regfile_wren, ir_wren, pc_inc, mem_wren, load_from_mem, raddr_31_20, halted, illegal}
    assign w_outs1 = {rf_1, ir_1, pc_1, mw_1, lm_1, ra_1, h_1, il_1};
    assign w_outs2 = {rf_2, ir_2, pc_2, mw_2, lm_2, ra_2, h_2, il_2};

    // Expected per-cycle output vectors from FETCH entry for one instruction.
    task automatic push_instr(input int which, input int lat, input logic [6:0] opc,
                              input int halt_cycles);
        logic [7:0] v[$];
        for (int k = 0; k < lat; k++) v.push_back((k == lat - 1) ? 8'b0110_0000 : 8'h00);
        v.push_back(8'h00);
        case (opc)
            T_OP:     v.push_back(8'b1000_0000);
            T_LOAD: begin
                for (int k = 0; k < lat; k++) v.push_back(8'b0000_0100);
                v.push_back(8'b1000_1100);
            end
            T_STORE:  v.push_back(8'b0001_0100);
            T_SYSTEM: for (int k = 0; k < halt_cycles; k++) v.push_back(8'b0000_0010);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int k = 0; k < halt_cycles; k++) v.push_back(8'b0000_0011);
`endif
            end
        endcase
        foreach (v[i]) begin
            if (which == 1) q1.push_back(v[i]);
            else            q2.push_back(v[i]);
        end
    endtask

    task automatic apply_reset(input logic [6:0] opc);
        rst        = 1'b0;
        flash_busy = 1'b0;
        opcode     = opc;
        q1.delete();
        q2.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flash_busy = 1'b0; opcode = T_OP;
        repeat (3) @(negedge clk);
        n_checks++;
        if (w_outs1 !== 8'h00 || instret_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_l1 outs=%b instret=%0d expected outs=00000000 instret=0", w_outs1, instret_1);
        end
        n_checks++;
        if (w_outs2 !== 8'h00 || instret_2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_l2 outs=%b instret=%0d expected outs=00000000 instret=0", w_outs2, instret_2);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (w_outs1 !== 8'b0110_0000) begin
            n_fail++;
            $display("FAIL first_fetch_l1 outs=%b expected 01100000", w_outs1);
        end
        n_checks++;
        if (w_outs2 !== 8'h00) begin
            n_fail++;
            $display("FAIL first_fetch_l2_c0 outs=%b expected 00000000", w_outs2);
        end
        @(negedge clk);
        n_checks++;
        if (ir_2 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch_l2_c1 ir_wren=%b expected 1", ir_2);
        end
    endtask

    task automatic test_flash_busy();
        rst = 1'b0; flash_busy = 1'b1; opcode = T_OP;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (w_outs1 !== 8'h00) begin
                n_fail++;
                $display("FAIL flash_busy_idle cycle=%0d outs=%b expected 00000000", c, w_outs1);
            end
        end
        flash_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ir_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL flash_busy_release ir_wren=%b expected 1", ir_1);
        end
    endtask

    task automatic test_op_stream();
        logic [7:0] exp;
        apply_reset(T_OP);
        for (int i = 0; i < 4; i++) push_instr(1, 1, T_OP, 0);
        for (int c = 0; c < 200 && (q1.size() > 0 || q2.size() > 0); c++) begin
            @(negedge clk);
            if (q1.size() > 0) begin
                exp = q1.pop_front();
                n_checks++;
                if (w_outs1 !== exp) begin
                    n_fail++;
                    $display("FAIL op_stream_l1 cycle=%0d outs=%b expected %b", c, w_outs1, exp);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (instret_1 !== 32'd4) begin
            n_fail++;
            $display("FAIL op_stream_instret got=%0d expected 4", instret_1);
        end
    endtask

    task automatic test_load_store();
        logic [7:0] exp;
        apply_reset(T_LOAD);
        push_instr(2, 2, T_LOAD, 0);
        for (int c = 0; c < 200 && q2.size() > 0; c++) begin
            @(negedge clk);
            exp = q2.pop_front();
            n_checks++;
            if (w_outs2 !== exp) begin
                n_fail++;
                $display("FAIL load_l2 cycle=%0d outs=%b expected %b", c, w_outs2, exp);
            end
        end
        opcode = T_STORE;
        push_instr(2, 2, T_STORE, 0);
        for (int c = 0; c < 200 && q2.size() > 0; c++) begin
            @(negedge clk);
            exp = q2.pop_front();
            n_checks++;
            if (w_outs2 !== exp) begin
                n_fail++;
                $display("FAIL store_l2 cycle=%0d outs=%b expected %b", c, w_outs2, exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (instret_2 !== 32'd2) begin
            n_fail++;
            $display("FAIL load_store_instret got=%0d expected 2", instret_2);
        end
        // Second STORE: fetch cycle 1, decode, then store cycle where reset hits.
        repeat (3) @(negedge clk);
        n_checks++;
        if (mw_2 !== 1'b1) begin
            n_fail++;
            $display("FAIL store_pulse mem_wren=%b expected 1", mw_2);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (mw_2 !== 1'b0 || instret_2 !== 32'd0) begin
            n_fail++;
            $display("FAIL async_abort mem_wren=%b instret=%0d expected 0 and 0", mw_2, instret_2);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_system();
        logic [7:0] exp;
        apply_reset(T_SYSTEM);
        push_instr(1, 1, T_SYSTEM, 20);
        push_instr(2, 2, T_SYSTEM, 20);
        for (int c = 0; c < 200 && (q1.size() > 0 || q2.size() > 0); c++) begin
            @(negedge clk);
            if (q1.size() > 0) begin
                exp = q1.pop_front();
                n_checks++;
                if (w_outs1 !== exp) begin
                    n_fail++;
                    $display("FAIL system_l1 cycle=%0d outs=%b expected %b", c, w_outs1, exp);
                end
            end
            if (q2.size() > 0) begin
                exp = q2.pop_front();
                n_checks++;
                if (w_outs2 !== exp) begin
                    n_fail++;
                    $display("FAIL system_l2 cycle=%0d outs=%b expected %b", c, w_outs2, exp);
                end
            end
        end
        n_checks++;
        if (instret_1 !== 32'd0 || instret_2 !== 32'd0) begin
            n_fail++;
            $display("FAIL system_no_retire instret=%0d/%0d expected 0/0", instret_1, instret_2);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (h_1 !== 1'b0 || h_2 !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset halted=%b/%b expected 0/0", h_1, h_2);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ir_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_restart ir_wren=%b expected 1", ir_1);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] exp;
        apply_reset(T_ILL);
`ifdef ILLEGAL_TRAP_EN
        push_instr(1, 1, T_ILL, 6);
`else
        push_instr(1, 1, T_ILL, 0);
        push_instr(1, 1, T_ILL, 0);
        q1.push_back(8'b0110_0000);
`endif
        for (int c = 0; c < 200 && q1.size() > 0; c++) begin
            @(negedge clk);
            exp = q1.pop_front();
            n_checks++;
            if (w_outs1 !== exp) begin
                n_fail++;
                $display("FAIL illegal_l1 cycle=%0d outs=%b expected %b", c, w_outs1, exp);
            end
        end
        n_checks++;
        if (instret_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL illegal_no_retire instret=%0d expected 0", instret_1);
        end
    endtask

    initial begin
        test_reset();
        test_flash_busy();
        test_op_stream();
        test_load_store();
        test_system();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
